// File: rtl/pipeline_hazard_if.sv
// Hazard-control bundle between the CPU pipeline and the stall/flush sequencer.
// The pipeline side is the master. The sequencer is the slave.
interface pipeline_hazard_if;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [3:0] ex_reg_dst;
  logic       ex_mem_rd;
  logic       mem_req;
  logic       mem_ack;
  logic       branch_taken;
  logic       irq;
  logic       returni_ex;
  logic       stall_pc;
  logic       stall_if_id;
  logic       stall_id_ex;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       int_inject;
  logic       in_isr;
  logic       mem_err;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_reg_dst, ex_mem_rd,
           mem_req, mem_ack, branch_taken, irq, returni_ex,
    input  stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           int_inject, in_isr, mem_err
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_reg_dst, ex_mem_rd,
           mem_req, mem_ack, branch_taken, irq, returni_ex,
    output stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex,
           int_inject, in_isr, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, memory-wait freeze,
// branch flushes, interrupt drain/inject, in-ISR tracking and a sticky memory-timeout error.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipeline_hazard_if.slave hz
);

  localparam int              TO_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [3:0]      DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX     = TO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, DRAIN, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      drain_cnt, drain_cnt_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            in_isr_q;
  logic            mem_err_q;
  logic            mw;
  logic            src_match;
  logic            lu;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v >= TO_MAX) ? TO_MAX : v + 1'b1;
  endfunction

  assign mw        = hz.mem_req && !hz.mem_ack;
  assign src_match = (hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_reg_dst)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_reg_dst));
  assign lu        = hz.ex_mem_rd && src_match && !hz.branch_taken && !mw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // A memory wait freezes the sequence in place, so every transition requires !mw.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (hz.irq && !in_isr_q && !hz.branch_taken && !mw) begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!mw) begin
          if (drain_cnt == 4'd0) state_nxt = ISSUE;
          else                   drain_cnt_nxt = drain_cnt - 4'd1;
        end
      end
      ISSUE: begin
        if (!mw) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    hz.stall_pc    = 1'b0;
    hz.stall_if_id = 1'b0;
    hz.stall_id_ex = 1'b0;
    hz.flush_if_id = 1'b0;
    hz.flush_id_ex = 1'b0;
    hz.int_inject  = 1'b0;
    if (mw) begin
      hz.stall_pc    = 1'b1;
      hz.stall_if_id = 1'b1;
      hz.stall_id_ex = 1'b1;
    end else begin
      if (hz.branch_taken) begin
        hz.flush_if_id = 1'b1;
        hz.flush_id_ex = 1'b1;
      end
      if (lu) begin
        hz.stall_pc    = 1'b1;
        hz.stall_if_id = 1'b1;
        hz.flush_id_ex = 1'b1;
      end
      case (state)
        DRAIN: begin
          hz.stall_pc    = 1'b1;
          hz.flush_if_id = 1'b1;
        end
        ISSUE: begin
          hz.stall_pc   = 1'b1;
          hz.int_inject = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Entering the handler takes priority over a coincident return-from-interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_isr_q <= 1'b0;
    end else if (state == ISSUE && !mw) begin
      in_isr_q <= 1'b1;
    end else if (hz.returni_ex && !mw) begin
      in_isr_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      mem_err_q <= 1'b0;
    end else if (mw) begin
      to_cnt <= sat_inc(to_cnt);
      if (sat_inc(to_cnt) == TO_MAX) mem_err_q <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign hz.in_isr  = in_isr_q;
  assign hz.mem_err = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic for pipeline_hazard_ctrl, checked every cycle
// against a countdown-based reference model of the stall/flush/interrupt rules.
module tb_pipeline_hazard_ctrl;
  localparam int DC = 3;
  localparam int MT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_if hz();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: m_until = -1 when no interrupt entry is in progress, otherwise the
  // number of non-waiting cycles left before the inject cycle (0 = inject this cycle).
  int m_until;
  bit m_isr;
  bit m_err;
  int m_to;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic idle();
    hz.id_rs1 = 4'd0; hz.id_rs2 = 4'd0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_reg_dst = 4'd0; hz.ex_mem_rd = 1'b0; hz.mem_req = 1'b0; hz.mem_ack = 1'b0;
    hz.branch_taken = 1'b0; hz.irq = 1'b0; hz.returni_ex = 1'b0;
  endtask

  task automatic model_reset();
    m_until = -1; m_isr = 1'b0; m_err = 1'b0; m_to = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall_pc"},    hz.stall_pc,    1'b0);
    chk({tag, "_stall_if_id"}, hz.stall_if_id, 1'b0);
    chk({tag, "_stall_id_ex"}, hz.stall_id_ex, 1'b0);
    chk({tag, "_flush_if_id"}, hz.flush_if_id, 1'b0);
    chk({tag, "_flush_id_ex"}, hz.flush_id_ex, 1'b0);
    chk({tag, "_int_inject"},  hz.int_inject,  1'b0);
    chk({tag, "_in_isr"},      hz.in_isr,      1'b0);
    chk({tag, "_mem_err"},     hz.mem_err,     1'b0);
  endtask

  // Called at a falling edge with inputs applied: check, advance model, move to next negedge.
  task automatic tick();
    logic mw, br, lu, e_spc, e_sif, e_sid, e_fif, e_fid, e_inj;
    bit   nisr;
    #1;
    mw = hz.mem_req && !hz.mem_ack;
    br = hz.branch_taken;
    lu = hz.ex_mem_rd && !br &&
         ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_reg_dst) ||
          (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_reg_dst));
    if (mw) begin
      e_spc = 1'b1; e_sif = 1'b1; e_sid = 1'b1; e_fif = 1'b0; e_fid = 1'b0; e_inj = 1'b0;
    end else begin
      e_sid = 1'b0;
      e_sif = lu;
      e_spc = lu || (m_until >= 0);
      e_fif = br || (m_until > 0);
      e_fid = br || lu;
      e_inj = (m_until == 0);
    end
    chk("stall_pc",    hz.stall_pc,    e_spc);
    chk("stall_if_id", hz.stall_if_id, e_sif);
    chk("stall_id_ex", hz.stall_id_ex, e_sid);
    chk("flush_if_id", hz.flush_if_id, e_fif);
    chk("flush_id_ex", hz.flush_id_ex, e_fid);
    chk("int_inject",  hz.int_inject,  e_inj);
    chk("in_isr",      hz.in_isr,      m_isr);
    chk("mem_err",     hz.mem_err,     m_err);
    if (mw) begin
      m_to = (m_to < MT) ? m_to + 1 : MT;
      if (m_to == MT) m_err = 1'b1;
    end else begin
      m_to = 0;
      nisr = m_isr;
      if (hz.returni_ex) nisr = 1'b0;
      if (m_until == 0) begin
        m_until = -1;
        nisr    = 1'b1;
      end else if (m_until > 0) begin
        m_until--;
      end else if (hz.irq && !m_isr && !br) begin
        m_until = DC;
      end
      m_isr = nisr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Load-use on rs2 gives a single bubble, then a non-load in EX clears it.
    hz.ex_mem_rd = 1'b1; hz.ex_reg_dst = 4'd5; hz.id_rs2 = 4'd5; hz.id_uses_rs2 = 1'b1;
    #1;
    chk("lu_stall_pc", hz.stall_pc, 1'b1);
    chk("lu_stall_if_id", hz.stall_if_id, 1'b1);
    chk("lu_flush_id_ex", hz.flush_id_ex, 1'b1);
    tick();
    hz.ex_mem_rd = 1'b0;
    #1;
    chk("lu_release", hz.stall_pc, 1'b0);
    tick();
    hz.ex_mem_rd = 1'b1; hz.id_uses_rs2 = 1'b0;
    #1;
    chk("lu_unused_src", hz.stall_pc, 1'b0);
    tick();
    idle();

    // Memory wait with a pending branch: stall only, then the flush pair on the ack cycle.
    hz.mem_req = 1'b1; hz.branch_taken = 1'b1;
    repeat (4) begin
      #1;
      chk("mw_stall_id_ex", hz.stall_id_ex, 1'b1);
      chk("mw_no_flush", hz.flush_if_id, 1'b0);
      tick();
    end
    hz.mem_ack = 1'b1;
    #1;
    chk("ack_flush_if_id", hz.flush_if_id, 1'b1);
    chk("ack_flush_id_ex", hz.flush_id_ex, 1'b1);
    chk("ack_no_stall", hz.stall_pc, 1'b0);
    tick();
    idle();
    #1;
    chk("mw_no_err", hz.mem_err, 1'b0);
    tick();

    // Interrupt: one-cycle irq, three drain cycles, inject, then in_isr.
    hz.irq = 1'b1;
    tick();
    hz.irq = 1'b0;
    repeat (DC) begin
      #1;
      chk("drain_flush_if_id", hz.flush_if_id, 1'b1);
      chk("drain_no_inject", hz.int_inject, 1'b0);
      tick();
    end
    #1;
    chk("inject", hz.int_inject, 1'b1);
    tick();
    #1;
    chk("in_isr_set", hz.in_isr, 1'b1);
    tick();
    hz.irq = 1'b1;
    repeat (3) begin
      #1;
      chk("irq_in_isr_ignored", hz.flush_if_id, 1'b0);
      tick();
    end
    hz.irq = 1'b0;
    hz.returni_ex = 1'b1;
    tick();
    hz.returni_ex = 1'b0;
    #1;
    chk("in_isr_clear", hz.in_isr, 1'b0);
    tick();

    // Interrupt with two memory-wait cycles inside the drain: inject at N+6.
    hz.irq = 1'b1;
    tick();
    hz.irq = 1'b0;
    tick();
    hz.mem_req = 1'b1;
    tick();
    tick();
    hz.mem_req = 1'b0;
    tick();
    tick();
    #1;
    chk("inject_after_wait", hz.int_inject, 1'b1);
    tick();
    hz.returni_ex = 1'b1;
    tick();
    hz.returni_ex = 1'b0;
    tick();

    // Timeout: sixteen consecutive wait cycles set the sticky error.
    hz.mem_req = 1'b1;
    repeat (MT - 1) tick();
    #1;
    chk("err_not_yet", hz.mem_err, 1'b0);
    tick();
    #1;
    chk("err_set", hz.mem_err, 1'b1);
    chk("err_still_stalled", hz.stall_pc, 1'b1);
    tick();
    hz.mem_ack = 1'b1;
    tick();
    idle();
    #1;
    chk("err_sticky", hz.mem_err, 1'b1);
    tick();

    // Reset in the middle of a drain aborts it.
    hz.irq = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid_drain");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    hz.irq = 1'b0;
    rst_n = 1'b1;
    repeat (DC + 3) tick();

    // Randomized traffic with a small register range to provoke matches.
    repeat (400) begin
      hz.id_rs1       = 4'($urandom_range(0, 3));
      hz.id_rs2       = 4'($urandom_range(0, 3));
      hz.ex_reg_dst   = 4'($urandom_range(0, 3));
      hz.id_uses_rs1  = ($urandom_range(0, 1) == 1);
      hz.id_uses_rs2  = ($urandom_range(0, 1) == 1);
      hz.ex_mem_rd    = ($urandom_range(0, 9) < 4);
      hz.mem_req      = ($urandom_range(0, 9) < 3);
      hz.mem_ack      = ($urandom_range(0, 1) == 1);
      hz.branch_taken = ($urandom_range(0, 99) < 15);
      hz.irq          = ($urandom_range(0, 9) < 2);
      hz.returni_ex   = ($urandom_range(0, 9) < 1);
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
